// File: rtl/pipe_hazard_unit_pkg.sv
// Shared constants for the hazard/forwarding controller: forwarding-select
// encoding, scoreboard entry field widths and the register address width.
package pipe_hazard_unit_pkg;

  localparam int unsigned ASIZE_DEF = 4;
  localparam int unsigned SB_FLAG_W = 1;
  localparam int unsigned FWD_RF    = 0;

  // Entry = {v, wen, waddr, load}
  function automatic int unsigned sb_entry_w(input int unsigned asize);
    return 3 * SB_FLAG_W + asize;
  endfunction

  // The WB-retained value sits one slot past the last pipeline register
  function automatic int unsigned fwd_wbq(input int unsigned nstages);
    return nstages;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// Per-operand scoreboard lookup: finds the youngest in-flight writer of raddr
// and whether its result can be forwarded yet.
module haz_match
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned ASIZE    = ASIZE_DEF,
  parameter int unsigned NSTAGES  = 3,
  parameter int unsigned ALU_LAT  = 1,
  parameter int unsigned LOAD_LAT = 2,
  parameter bit          FWD_EN   = 1'b1,
  localparam int unsigned IDXW    = idx_w(NSTAGES)
) (
  input  logic                            en,
  input  logic [ASIZE-1:0]                raddr,
  input  logic [NSTAGES-1:0]              sb_v,
  input  logic [NSTAGES-1:0]              sb_wen,
  input  logic [NSTAGES-1:0]              sb_load,
  input  logic [NSTAGES-1:0][ASIZE-1:0]   sb_waddr,
  output logic                            hit_c,
  output logic                            ready_c,
  output logic [IDXW-1:0]                 idx_c
);

  // Scan oldest to youngest so the smallest matching index wins
  always_comb begin
    hit_c   = 1'b0;
    ready_c = 1'b0;
    idx_c   = '0;
    for (int s = int'(NSTAGES) - 1; s >= 0; s--) begin
      if (en && sb_v[s] && sb_wen[s] && (sb_waddr[s] == raddr)) begin
        hit_c   = 1'b1;
        idx_c   = IDXW'(s);
        ready_c = FWD_EN &&
                  ((s + 1) >= (sb_load[s] ? int'(LOAD_LAT) : int'(ALU_LAT)));
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the instruction in ID. Define HAZ_FWD_EN
// for full bypassing; otherwise the unit interlocks until producers retire.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned ASIZE    = ASIZE_DEF,
  parameter int unsigned NSTAGES  = 3,
  parameter int unsigned ALU_LAT  = 1,
  parameter int unsigned LOAD_LAT = 2,
  localparam int unsigned FSW     = $clog2(NSTAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [ASIZE-1:0] id_raddr1,
  input  logic [ASIZE-1:0] id_raddr2,
  input  logic             id_use2,
  input  logic             id_wen,
  input  logic [ASIZE-1:0] id_waddr,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush,
  output logic [FSW-1:0]   fwd_sel1_ex,
  output logic [FSW-1:0]   fwd_sel2_ex
);

`ifdef HAZ_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  localparam int unsigned IDXW = idx_w(NSTAGES);

  logic [NSTAGES-1:0]            sb_v_q, sb_v_d;
  logic [NSTAGES-1:0]            sb_wen_q, sb_wen_d;
  logic [NSTAGES-1:0]            sb_load_q, sb_load_d;
  logic [NSTAGES-1:0][ASIZE-1:0] sb_waddr_q, sb_waddr_d;
  logic [FSW-1:0]                fwd_sel1_q, fwd_sel1_d;
  logic [FSW-1:0]                fwd_sel2_q, fwd_sel2_d;

  logic            hit1_c, ready1_c, hit2_c, ready2_c;
  logic [IDXW-1:0] idx1_c, idx2_c;
  logic            stall_c, flush_c, adv_c;

  haz_match #(
    .ASIZE(ASIZE), .NSTAGES(NSTAGES), .ALU_LAT(ALU_LAT),
    .LOAD_LAT(LOAD_LAT), .FWD_EN(FWD_EN)
  ) u_match1 (
    .en(1'b1), .raddr(id_raddr1),
    .sb_v(sb_v_q), .sb_wen(sb_wen_q), .sb_load(sb_load_q), .sb_waddr(sb_waddr_q),
    .hit_c(hit1_c), .ready_c(ready1_c), .idx_c(idx1_c)
  );

  haz_match #(
    .ASIZE(ASIZE), .NSTAGES(NSTAGES), .ALU_LAT(ALU_LAT),
    .LOAD_LAT(LOAD_LAT), .FWD_EN(FWD_EN)
  ) u_match2 (
    .en(id_use2), .raddr(id_raddr2),
    .sb_v(sb_v_q), .sb_wen(sb_wen_q), .sb_load(sb_load_q), .sb_waddr(sb_waddr_q),
    .hit_c(hit2_c), .ready_c(ready2_c), .idx_c(idx2_c)
  );

  // Flush dominates; without bypassing ready is never set, so any hit stalls
  always_comb begin
    flush_c = ex_branch_taken;
    stall_c = id_valid & ~flush_c & ((hit1_c & ~ready1_c) | (hit2_c & ~ready2_c));
    adv_c   = id_valid & ~stall_c & ~flush_c;
  end

  always_comb begin
    sb_v_d     = {sb_v_q[NSTAGES-2:0], adv_c & id_wen};
    sb_wen_d   = {sb_wen_q[NSTAGES-2:0], id_wen};
    sb_load_d  = {sb_load_q[NSTAGES-2:0], id_is_load};
    sb_waddr_d = {sb_waddr_q[NSTAGES-2:0], id_waddr};

    fwd_sel1_d = FSW'(FWD_RF);
    fwd_sel2_d = FSW'(FWD_RF);
    if (adv_c && hit1_c && ready1_c) fwd_sel1_d = FSW'(idx1_c) + FSW'(1);
    if (adv_c && hit2_c && ready2_c) fwd_sel2_d = FSW'(idx2_c) + FSW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_v_q     <= '0;
      sb_wen_q   <= '0;
      sb_load_q  <= '0;
      sb_waddr_q <= '0;
      fwd_sel1_q <= '0;
      fwd_sel2_q <= '0;
    end else begin
      sb_v_q     <= sb_v_d;
      sb_wen_q   <= sb_wen_d;
      sb_load_q  <= sb_load_d;
      sb_waddr_q <= sb_waddr_d;
      fwd_sel1_q <= fwd_sel1_d;
      fwd_sel2_q <= fwd_sel2_d;
    end
  end

  assign stall       = stall_c;
  assign flush       = flush_c;
  assign fwd_sel1_ex = fwd_sel1_q;
  assign fwd_sel2_ex = fwd_sel2_q;

endmodule
